// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_responder
// Purpose  : Synchronous memory slave for the 8227 CPU bus. Serves reads
//            combinationally from RAM, the vector registers or a NOP filler.
//            Commits CPU writes after a programmable number of wait states,
//            and accepts host-loader writes with priority over the CPU.
// Ports    : clk, nrst                 - clock, async active-low reset
//            AddressBusHigh/Low        - CPU address {high, low}
//            readNotWrite              - 1 = CPU read, 0 = CPU write
//            dataBusOutput             - CPU write data
//            dataBusInput              - read data to the CPU (combinational)
//            ready                     - CPU access completes this cycle
//            load_en/addr/data         - host loader write port
//            load_ack                  - one-cycle pulse after each load
//            write_count               - committed CPU writes, saturating
//            bus_err                   - sticky illegal CPU write flag
// Revision : 1.0 - initial release
// ============================================================================
module bus_mem_responder #(
    parameter int          DEPTH        = 4096,
    parameter int          WAIT_STATES  = 0,
    parameter logic [15:0] NMI_VECTOR   = 16'hCCCA,
    parameter logic [15:0] RESET_VECTOR = 16'hCCDB,
    parameter logic [15:0] IRQ_VECTOR   = 16'hCCCA
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  AddressBusHigh,
    input  logic [7:0]  AddressBusLow,
    input  logic        readNotWrite,
    input  logic [7:0]  dataBusOutput,
    output logic [7:0]  dataBusInput,
    output logic        ready,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        load_ack,
    output logic [15:0] write_count,
    output logic        bus_err
);

    localparam int          c_addr_w = $clog2(DEPTH);
    localparam logic [16:0] c_depth  = 17'(DEPTH);
    localparam logic [3:0]  c_ws     = 4'(WAIT_STATES);
    localparam logic [15:0] c_vec_lo = 16'hFFFA;

    // RAM: no reset, so loader contents survive nrst.
    logic [7:0]          mem_q [DEPTH];
    logic                mem_we;
    logic [c_addr_w-1:0] mem_waddr;
    logic [7:0]          mem_wdata;

    // Vector bytes, index 0 = FFFA ... index 5 = FFFF.
    logic [7:0]  vec_q [6];
    logic [7:0]  vec_d [6];

    logic [3:0]  cnt_q, cnt_d;
    logic        load_ack_q, load_ack_d;
    logic [15:0] write_count_q, write_count_d;
    logic        bus_err_q, bus_err_d;

    logic [15:0] cpu_addr;
    logic        cpu_is_ram, cpu_is_vec;
    logic [2:0]  cpu_vidx;
    logic        ld_is_ram, ld_is_vec;
    logic [2:0]  ld_vidx;

    always_comb begin
        cpu_addr   = {AddressBusHigh, AddressBusLow};
        cpu_is_ram = {1'b0, cpu_addr} < c_depth;
        cpu_is_vec = cpu_addr >= c_vec_lo;
        cpu_vidx   = cpu_addr[2:0] - 3'd2;
        ld_is_ram  = {1'b0, load_addr} < c_depth;
        ld_is_vec  = load_addr >= c_vec_lo;
        ld_vidx    = load_addr[2:0] - 3'd2;
    end

    // Read path is purely combinational so data is valid in every ready cycle.
    always_comb begin
        dataBusInput = 8'hEA;
        if (cpu_is_ram) begin
            dataBusInput = mem_q[cpu_addr[c_addr_w-1:0]];
        end else if (cpu_is_vec) begin
            dataBusInput = vec_q[cpu_vidx];
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        load_ack_d    = load_en;
        write_count_d = write_count_q;
        bus_err_d     = bus_err_q;
        vec_d         = vec_q;
        mem_we        = 1'b0;
        mem_waddr     = cpu_addr[c_addr_w-1:0];
        mem_wdata     = dataBusOutput;

        if (load_en) begin
            // Loader wins; the stall count is frozen and any CPU access waits.
            mem_waddr = load_addr[c_addr_w-1:0];
            mem_wdata = load_data;
            if (ld_is_ram) begin
                mem_we = 1'b1;
            end else if (ld_is_vec) begin
                vec_d[ld_vidx] = load_data;
            end
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = c_ws;
            if (!readNotWrite) begin
                if (cpu_is_ram) begin
                    // The RAM port ignores reset, so block CPU commits here.
                    mem_we = nrst;
                    if (write_count_q != 16'hFFFF) begin
                        write_count_d = write_count_q + 16'd1;
                    end
                end else begin
                    bus_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q         <= c_ws;
            load_ack_q    <= 1'b0;
            write_count_q <= 16'd0;
            bus_err_q     <= 1'b0;
            vec_q[0]      <= NMI_VECTOR[7:0];
            vec_q[1]      <= NMI_VECTOR[15:8];
            vec_q[2]      <= RESET_VECTOR[7:0];
            vec_q[3]      <= RESET_VECTOR[15:8];
            vec_q[4]      <= IRQ_VECTOR[7:0];
            vec_q[5]      <= IRQ_VECTOR[15:8];
        end else begin
            cnt_q         <= cnt_d;
            load_ack_q    <= load_ack_d;
            write_count_q <= write_count_d;
            bus_err_q     <= bus_err_d;
            vec_q         <= vec_d;
        end
    end

    assign ready       = (cnt_q == 4'd0) && !load_en;
    assign load_ack    = load_ack_q;
    assign write_count = write_count_q;
    assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bus_mem_responder
// Purpose  : Directed self-checking bench for bus_mem_responder. Instance 0
//            runs with no wait states, instance 1 with three wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mem_responder;

    logic        clk;
    logic        nrst    [2];
    logic [7:0]  ah      [2];
    logic [7:0]  al      [2];
    logic        rnw     [2];
    logic [7:0]  dout    [2];
    logic [7:0]  din     [2];
    logic        ready   [2];
    logic        load_en [2];
    logic [15:0] laddr   [2];
    logic [7:0]  ldata   [2];
    logic        load_ack[2];
    logic [15:0] wcnt    [2];
    logic        bus_err [2];

    int checks = 0;
    int errors = 0;

    bus_mem_responder #(.DEPTH(4096), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .nrst(nrst[0]), .AddressBusHigh(ah[0]), .AddressBusLow(al[0]),
        .readNotWrite(rnw[0]), .dataBusOutput(dout[0]), .dataBusInput(din[0]),
        .ready(ready[0]), .load_en(load_en[0]), .load_addr(laddr[0]),
        .load_data(ldata[0]), .load_ack(load_ack[0]), .write_count(wcnt[0]),
        .bus_err(bus_err[0])
    );

    bus_mem_responder #(.DEPTH(4096), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .nrst(nrst[1]), .AddressBusHigh(ah[1]), .AddressBusLow(al[1]),
        .readNotWrite(rnw[1]), .dataBusOutput(dout[1]), .dataBusInput(din[1]),
        .ready(ready[1]), .load_en(load_en[1]), .load_addr(laddr[1]),
        .load_data(ldata[1]), .load_ack(load_ack[1]), .write_count(wcnt[1]),
        .bus_err(bus_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [15:0] a);
        ah[i] = a[15:8];
        al[i] = a[7:0];
    endtask

    task automatic load(input int i, input logic [15:0] a, input logic [7:0] d);
        load_en[i] = 1'b1;
        laddr[i]   = a;
        ldata[i]   = d;
        step();
        load_en[i] = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ready[i] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_ready[%0d]: ready stayed %b, required 1 within 20 cycles", i, ready[i]);
        end
    endtask

    task automatic test_reset();
        logic [15:0] addrs [7] = '{16'hFFFA, 16'hFFFB, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h9000};
        logic [7:0]  exps  [7] = '{8'hCA, 8'hCC, 8'hDB, 8'hCC, 8'hCA, 8'hCC, 8'hEA};
        step();
        step();
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready_ws0: got %b required 1", ready[0]); end
        checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL reset_ready_ws3: got %b required 0", ready[1]); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (wcnt[i] !== 16'd0) begin errors++; $display("FAIL reset_wcnt[%0d]: got %h required 0000", i, wcnt[i]); end
            checks++; if (bus_err[i] !== 1'b0) begin errors++; $display("FAIL reset_bus_err[%0d]: got %b required 0", i, bus_err[i]); end
            checks++; if (load_ack[i] !== 1'b0) begin errors++; $display("FAIL reset_load_ack[%0d]: got %b required 0", i, load_ack[i]); end
        end
        for (int k = 0; k < 7; k++) begin
            set_addr(0, addrs[k]);
            #1;
            checks++;
            if (din[0] !== exps[k]) begin
                errors++;
                $display("FAIL reset_read %h: got %h required %h", addrs[k], din[0], exps[k]);
            end
        end
    endtask

    task automatic test_preload();
        logic [7:0] prog [3] = '{8'hA9, 8'h42, 8'hEA};
        logic [15:0] pc;
        // Loader during reset writes RAM but load_ack stays cleared.
        for (int k = 0; k < 3; k++) load(0, 16'h0200 + 16'(k), prog[k]);
        load(0, 16'hCCDB, 8'h11);
        checks++; if (load_ack[0] !== 1'b0) begin errors++; $display("FAIL preload_ack_in_reset: got %b required 0", load_ack[0]); end
        load(1, 16'h0001, 8'h07);
        load(1, 16'h0005, 8'h00);
        load(1, 16'h0006, 8'h00);
        load(1, 16'h0008, 8'h5A);
        nrst[0] = 1'b1;
        nrst[1] = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            set_addr(0, 16'h0200 + 16'(k));
            #1;
            checks++; if (din[0] !== prog[k]) begin errors++; $display("FAIL preload_ram %0d: got %h required %h", k, din[0], prog[k]); end
        end
        set_addr(0, 16'hCCDB);
        #1;
        checks++; if (din[0] !== 8'hEA) begin errors++; $display("FAIL preload_unmapped_drop: got %h required EA", din[0]); end
        // Retarget the reset vector to the program, watching each ack.
        load_en[0] = 1'b1; laddr[0] = 16'hFFFC; ldata[0] = 8'h00;
        #1;
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL load_ready_low: got %b required 0", ready[0]); end
        step();
        laddr[0] = 16'hFFFD; ldata[0] = 8'h02;
        checks++; if (load_ack[0] !== 1'b1) begin errors++; $display("FAIL load_ack_lo: got %b required 1", load_ack[0]); end
        step();
        load_en[0] = 1'b0;
        checks++; if (load_ack[0] !== 1'b1) begin errors++; $display("FAIL load_ack_hi: got %b required 1", load_ack[0]); end
        step();
        checks++; if (load_ack[0] !== 1'b0) begin errors++; $display("FAIL load_ack_drop: got %b required 0", load_ack[0]); end
        // Fetch sequence as the CPU would perform it.
        set_addr(0, 16'hFFFC); #1; pc[7:0]  = din[0];
        set_addr(0, 16'hFFFD); #1; pc[15:8] = din[0];
        checks++; if (pc !== 16'h0200) begin errors++; $display("FAIL fetch_vector: got %h required 0200", pc); end
        set_addr(0, pc); #1;
        checks++; if (din[0] !== 8'hA9) begin errors++; $display("FAIL fetch_opcode: got %h required A9", din[0]); end
        set_addr(0, pc + 16'd1); #1;
        checks++; if (din[0] !== 8'h42) begin errors++; $display("FAIL fetch_operand: got %h required 42", din[0]); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            load_en[0] = 1'b1;
            laddr[0]   = 16'h0300 + 16'(k);
            ldata[0]   = 8'h31 + 8'(k);
            step();
            checks++; if (load_ack[0] !== 1'b1) begin errors++; $display("FAIL b2b_ack %0d: got %b required 1", k, load_ack[0]); end
        end
        load_en[0] = 1'b0;
        step();
        checks++; if (load_ack[0] !== 1'b0) begin errors++; $display("FAIL b2b_ack_end: got %b required 0", load_ack[0]); end
        for (int k = 0; k < 3; k++) begin
            set_addr(0, 16'h0300 + 16'(k));
            #1;
            checks++; if (din[0] !== 8'h31 + 8'(k)) begin errors++; $display("FAIL b2b_data %0d: got %h required %h", k, din[0], 8'h31 + 8'(k)); end
        end
    endtask

    task automatic test_cpu_write();
        set_addr(0, 16'h0002); dout[0] = 8'h23; rnw[0] = 1'b0;
        step();
        rnw[0] = 1'b1;
        #1;
        checks++; if (din[0] !== 8'h23) begin errors++; $display("FAIL sta_data: got %h required 23", din[0]); end
        checks++; if (wcnt[0] !== 16'd1) begin errors++; $display("FAIL sta_count: got %0d required 1", wcnt[0]); end
        set_addr(0, 16'h0010); rnw[0] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            dout[0] = 8'(k);
            step();
        end
        rnw[0] = 1'b1;
        #1;
        checks++; if (wcnt[0] !== 16'd301) begin errors++; $display("FAIL loop_count: got %0d required 301", wcnt[0]); end
        checks++; if (din[0] !== 8'h2B) begin errors++; $display("FAIL loop_last_data: got %h required 2B", din[0]); end
    endtask

    task automatic test_bus_err();
        checks++; if (bus_err[0] !== 1'b0) begin errors++; $display("FAIL err_initial: got %b required 0", bus_err[0]); end
        set_addr(0, 16'hFFFC); dout[0] = 8'h55; rnw[0] = 1'b0;
        step();
        rnw[0] = 1'b1;
        #1;
        checks++; if (bus_err[0] !== 1'b1) begin errors++; $display("FAIL err_vector_write: got %b required 1", bus_err[0]); end
        checks++; if (din[0] !== 8'h00) begin errors++; $display("FAIL err_vector_kept: got %h required 00", din[0]); end
        set_addr(0, 16'h9000); dout[0] = 8'h66; rnw[0] = 1'b0;
        step();
        rnw[0] = 1'b1;
        repeat (3) step();
        checks++; if (din[0] !== 8'hEA) begin errors++; $display("FAIL err_unmapped_read: got %h required EA", din[0]); end
        checks++; if (wcnt[0] !== 16'd301) begin errors++; $display("FAIL err_count_kept: got %0d required 301", wcnt[0]); end
        checks++; if (bus_err[0] !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", bus_err[0]); end
    endtask

    task automatic test_saturate();
        set_addr(0, 16'h0010); dout[0] = 8'h5C; rnw[0] = 1'b0;
        repeat (65535 - 301 - 1) step();
        checks++; if (wcnt[0] !== 16'hFFFE) begin errors++; $display("FAIL sat_before: got %h required FFFE", wcnt[0]); end
        step();
        checks++; if (wcnt[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h required FFFF", wcnt[0]); end
        repeat (5) step();
        rnw[0] = 1'b1;
        checks++; if (wcnt[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h required FFFF", wcnt[0]); end
    endtask

    task automatic test_wait_read();
        int low = 0;
        set_addr(1, 16'h0001); rnw[1] = 1'b1;
        wait_ready(1);
        #1;
        checks++; if (din[1] !== 8'h07) begin errors++; $display("FAIL wait_data_first: got %h required 07", din[1]); end
        for (int n = 0; n < 8; n++) begin
            step();
            if (ready[1] === 1'b1) break;
            low++;
        end
        checks++; if (low != 3) begin errors++; $display("FAIL wait_low_cycles: got %0d required 3", low); end
        checks++; if (din[1] !== 8'h07) begin errors++; $display("FAIL wait_data_ready: got %h required 07", din[1]); end
    endtask

    task automatic test_load_stall();
        wait_ready(1);
        step();
        set_addr(1, 16'h0005); dout[1] = 8'h11; rnw[1] = 1'b0;
        #1;
        checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL stall_c3: got %b required 0", ready[1]); end
        step();
        load_en[1] = 1'b1; laddr[1] = 16'h0006; ldata[1] = 8'h66;
        step();
        load_en[1] = 1'b0;
        checks++; if (load_ack[1] !== 1'b1) begin errors++; $display("FAIL stall_load_ack: got %b required 1", load_ack[1]); end
        checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL stall_frozen: got %b required 0", ready[1]); end
        step();
        checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL stall_c1: got %b required 0", ready[1]); end
        step();
        checks++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL stall_resume: got %b required 1", ready[1]); end
        // Same-byte collision: the loader takes this cycle.
        load_en[1] = 1'b1; laddr[1] = 16'h0005; ldata[1] = 8'h99;
        #1;
        checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b required 0", ready[1]); end
        step();
        load_en[1] = 1'b0;
        #1;
        checks++; if (din[1] !== 8'h99) begin errors++; $display("FAIL collide_loader_wins: got %h required 99", din[1]); end
        checks++; if (wcnt[1] !== 16'd0) begin errors++; $display("FAIL collide_no_commit: got %0d required 0", wcnt[1]); end
        checks++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL collide_retry_ready: got %b required 1", ready[1]); end
        step();
        rnw[1] = 1'b1;
        #1;
        checks++; if (din[1] !== 8'h11) begin errors++; $display("FAIL retry_commit: got %h required 11", din[1]); end
        checks++; if (wcnt[1] !== 16'd1) begin errors++; $display("FAIL retry_count: got %0d required 1", wcnt[1]); end
        set_addr(1, 16'h0006);
        #1;
        checks++; if (din[1] !== 8'h66) begin errors++; $display("FAIL stall_loaded_byte: got %h required 66", din[1]); end
    endtask

    task automatic test_reset_mid_stall();
        int low = 0;
        wait_ready(1);
        step();
        set_addr(1, 16'h0008); dout[1] = 8'h77; rnw[1] = 1'b0;
        step();
        nrst[1] = 1'b0;
        #1;
        checks++; if (wcnt[1] !== 16'd0) begin errors++; $display("FAIL rst_stall_count: got %0d required 0", wcnt[1]); end
        step();
        step();
        rnw[1] = 1'b1;
        nrst[1] = 1'b1;
        #1;
        checks++; if (din[1] !== 8'h5A) begin errors++; $display("FAIL rst_stall_byte: got %h required 5A", din[1]); end
        checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL rst_stall_ready: got %b required 0", ready[1]); end
        for (int n = 0; n < 8; n++) begin
            step();
            if (ready[1] === 1'b1) break;
            low++;
        end
        checks++; if (low != 2) begin errors++; $display("FAIL rst_stall_reload: got %0d further low cycles required 2", low); end
        // Reset also clears the sticky error on the other instance.
        nrst[0] = 1'b0;
        #1;
        checks++; if (bus_err[0] !== 1'b0) begin errors++; $display("FAIL rst_clears_err: got %b required 0", bus_err[0]); end
        checks++; if (wcnt[0] !== 16'd0) begin errors++; $display("FAIL rst_clears_count: got %h required 0000", wcnt[0]); end
        step();
        nrst[0] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            nrst[i]    = 1'b0;
            ah[i]      = 8'h00;
            al[i]      = 8'h00;
            rnw[i]     = 1'b1;
            dout[i]    = 8'h00;
            load_en[i] = 1'b0;
            laddr[i]   = 16'h0000;
            ldata[i]   = 8'h00;
        end
        test_reset();
        test_preload();
        test_back_to_back();
        test_cpu_write();
        test_bus_err();
        test_saturate();
        test_wait_read();
        test_load_stall();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
